// File: rtl/uart_pkg.sv
// Shared state encoding and error-bit positions for the UART receive frame controller.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DONE = 2'd2
   } frameState_t;

   localparam int ERR_PARITY   = 0;
   localparam int ERR_OVERFLOW = 1;
   localparam int ERR_BREAK    = 2;
   localparam int ERR_TOO_LONG = 3;
   localparam int ERR_W        = 4;

endpackage

// File: rtl/uart_frame_ram.sv
// Simple dual-port frame buffer: synchronous write, registered read with a clear
// so an out-of-range read presents zero instead of stale data.
module uart_frame_ram #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int DATA_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [DATA_W-1:0] wrData,
   input  logic              rdEn,
   input  logic              rdClr,
   input  logic [ADDR_W-1:0] rdAddr,
   output logic [DATA_W-1:0] rdData
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wrEn) mem[wrAddr] <= wrData;
   end

   always_ff @(posedge clk) begin
      if (rst || rdClr) rdData <= '0;
      else if (rdEn)    rdData <= mem[rdAddr];
   end

endmodule

// File: rtl/uart_rx_frame_controller.sv
// Drains UartReceiver into a frame buffer, closes the frame on the rising edge of
// line silence, and holds the frame with length/error flags until the host acks it.
module uart_rx_frame_controller
   import uart_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic [8:0]      rx_data,
   input  logic            rx_valid,
   input  logic            rx_parity_err,
   input  logic            rx_overflow,
   input  logic            rx_break,
   input  logic            rx_silence,
   output logic            rx_req,
   output logic            frame_ready,
   output logic [ADDR_W:0] frame_len,
   output logic [3:0]      frame_err,
   input  logic            rd_en,
   output logic [8:0]      rd_data,
   input  logic            frame_ack
);

   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

   frameState_t     state, nextState;
   logic            reqQ, silenceQ, ovfPending;
   logic [ADDR_W:0] count, rdPtr;
   logic [3:0]      errFlags;
   logic            pop, storeEn, silenceRise, readReq, readStep, readEnd;

   // reqQ blocks a second pop while the receiver is still dropping rx_valid
   assign pop         = !rst && (state != ST_DONE) && enable && rx_valid && !reqQ;
   assign storeEn     = pop && (count != FULL);
   assign silenceRise = rx_silence && !silenceQ;
   assign readReq     = (state == ST_DONE) && rd_en && !frame_ack;
   assign readStep    = readReq && (rdPtr != count);
   assign readEnd     = readReq && (rdPtr == count);

   assign rx_req      = pop;
   assign frame_ready = (state == ST_DONE);
   assign frame_len   = frame_ready ? count : '0;
   assign frame_err   = frame_ready ? errFlags : '0;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE: if (enable && pop) nextState = ST_RECV;
         ST_RECV: begin
            if (!enable)         nextState = ST_IDLE;
            else if (silenceRise) nextState = ST_DONE;
         end
         ST_DONE: if (frame_ack) nextState = ST_IDLE;
         default: nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reqQ       <= 1'b0;
         silenceQ   <= 1'b0;
         ovfPending <= 1'b0;
         count      <= '0;
         rdPtr      <= '0;
         errFlags   <= '0;
      end else begin
         reqQ     <= pop;
         silenceQ <= rx_silence;
         if (state == ST_DONE) begin
            if (frame_ack) begin
               count                  <= '0;
               rdPtr                  <= '0;
               errFlags               <= '0;
               errFlags[ERR_OVERFLOW] <= ovfPending | rx_overflow;
               ovfPending             <= 1'b0;
            end else begin
               // overflow while the host owns the frame belongs to the next one
               if (rx_overflow) ovfPending <= 1'b1;
               if (readStep)    rdPtr      <= rdPtr + 1'b1;
            end
         end else if (!enable) begin
            count    <= '0;
            rdPtr    <= '0;
            errFlags <= '0;
         end else begin
            if (pop) begin
               if (storeEn) count <= count + 1'b1;
               else         errFlags[ERR_TOO_LONG] <= 1'b1;
               if (rx_parity_err) errFlags[ERR_PARITY] <= 1'b1;
            end
            if (rx_overflow)                      errFlags[ERR_OVERFLOW] <= 1'b1;
            if (rx_break && (state == ST_RECV))   errFlags[ERR_BREAK]    <= 1'b1;
         end
      end
   end

   uart_frame_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (9)
   ) frameRam (
      .clk    (clk),
      .rst    (rst),
      .wrEn   (storeEn),
      .wrAddr (count[ADDR_W-1:0]),
      .wrData (rx_data),
      .rdEn   (readStep),
      .rdClr  (readEnd),
      .rdAddr (rdPtr[ADDR_W-1:0]),
      .rdData (rd_data)
   );

endmodule

// File: tb/tb_uart_rx_frame_controller.sv
// Directed and randomized bench for uart_rx_frame_controller with a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_frame_controller;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = $clog2(DEPTH);

   logic            clk = 1'b0;
   logic            rst;
   logic            enable;
   logic [8:0]      rx_data;
   logic            rx_valid;
   logic            rx_parity_err;
   logic            rx_overflow;
   logic            rx_break;
   logic            rx_silence;
   logic            rx_req;
   logic            frame_ready;
   logic [ADDR_W:0] frame_len;
   logic [3:0]      frame_err;
   logic            rd_en;
   logic [8:0]      rd_data;
   logic            frame_ack;

   int         checks   = 0;
   int         failures = 0;
   int         reqCount = 0;
   logic [8:0] sent[$];
   logic [3:0] expErr;
   logic       ovfNext;

   uart_rx_frame_controller #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_parity_err (rx_parity_err),
      .rx_overflow   (rx_overflow),
      .rx_break      (rx_break),
      .rx_silence    (rx_silence),
      .rx_req        (rx_req),
      .frame_ready   (frame_ready),
      .frame_len     (frame_len),
      .frame_err     (frame_err),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .frame_ack     (frame_ack)
   );

   always #0.5 clk = ~clk;

   always @(posedge clk) if (rx_req) reqCount++;

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Receiver stand-in: hold the character until popped, drop valid the cycle after.
   task automatic sendChar(input logic [8:0] d, input logic pe);
      int waitCycles = 0;
      rx_data = d; rx_parity_err = pe; rx_valid = 1'b1;
      #0.1;
      while (!rx_req && waitCycles < 20) begin
         @(negedge clk); #0.1; waitCycles++;
      end
      check("pop_seen", 32'(rx_req), 32'd1);
      @(negedge clk);
      rx_valid = 1'b0; rx_parity_err = 1'b0; rx_data = '0;
      @(negedge clk);
      sent.push_back(d);
      if (pe) expErr[0] = 1'b1;
   endtask

   task automatic pulseOverflow();
      rx_overflow = 1'b1; @(negedge clk); rx_overflow = 1'b0;
   endtask

   task automatic pulseBreak();
      rx_break = 1'b1; @(negedge clk); rx_break = 1'b0;
   endtask

   task automatic endFrame();
      int w = 0;
      rx_silence = 1'b1; @(negedge clk); rx_silence = 1'b0;
      while (!frame_ready && w < 10) begin
         @(negedge clk); w++;
      end
      check("frame_ready_rise", 32'(frame_ready), 32'd1);
   endtask

   task automatic verifyFrame(input string tag);
      int         nSent  = sent.size();
      int         expLen = (nSent > DEPTH) ? DEPTH : nSent;
      logic [3:0] e      = expErr;
      logic [8:0] want;
      if (nSent > DEPTH) e[3] = 1'b1;
      check({tag, "_len"}, 32'(frame_len), 32'(expLen));
      check({tag, "_err"}, 32'(frame_err), 32'(e));
      for (int i = 0; i <= expLen; i++) begin
         want = (i < expLen) ? sent[i] : 9'd0;
         rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
         check({tag, "_rd"}, 32'(rd_data), 32'(want));
      end
      frame_ack = 1'b1; @(negedge clk); frame_ack = 1'b0;
      check({tag, "_released"}, 32'(frame_ready), 32'd0);
      check({tag, "_len_cleared"}, 32'(frame_len), 32'd0);
      sent.delete();
      expErr  = {2'b00, ovfNext, 1'b0};
      ovfNext = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_ready"}, 32'(frame_ready), 32'd0);
      check({tag, "_len"},   32'(frame_len),   32'd0);
      check({tag, "_err"},   32'(frame_err),   32'd0);
      check({tag, "_rd"},    32'(rd_data),     32'd0);
      check({tag, "_req"},   32'(rx_req),      32'd0);
   endtask

   initial begin
      int         base;
      int         n;
      logic [8:0] d;
      logic       pe;

      rst = 1'b1; enable = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_parity_err = 1'b0;
      rx_overflow = 1'b0; rx_break = 1'b0; rx_silence = 1'b0; rd_en = 1'b0; frame_ack = 1'b0;
      expErr = '0; ovfNext = 1'b0;
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
      @(negedge clk);

      sendChar(9'h041, 1'b0); sendChar(9'h042, 1'b0); sendChar(9'h043, 1'b0);
      endFrame(); verifyFrame("abc");

      sendChar(9'h055, 1'b1);
      endFrame(); verifyFrame("parity");

      sendChar(9'h011, 1'b0); pulseBreak(); expErr[2] = 1'b1; sendChar(9'h010, 1'b0);
      endFrame(); verifyFrame("break");

      base = reqCount;
      for (int i = 0; i < 6; i++) sendChar(9'h0A0 + 9'(i), 1'b0);
      endFrame();
      check("too_long_pops", 32'(reqCount - base), 32'd6);
      verifyFrame("too_long");

      // Frame held in DONE: receiver must not be popped, overflow deferred to next frame
      sendChar(9'h031, 1'b0);
      endFrame();
      rx_valid = 1'b1; rx_data = 9'h099;
      for (int i = 0; i < 4; i++) begin
         #0.1;
         check("done_no_pop", 32'(rx_req), 32'd0);
         check("done_holds", 32'(frame_ready), 32'd1);
         @(negedge clk);
      end
      rx_valid = 1'b0; rx_data = '0;
      pulseOverflow(); ovfNext = 1'b1;
      verifyFrame("hold");
      sendChar(9'h032, 1'b0);
      endFrame(); verifyFrame("pending_ovf");

      // Abort mid-collection discards characters and errors
      sendChar(9'h021, 1'b0); sendChar(9'h022, 1'b1);
      enable = 1'b0; @(negedge clk); enable = 1'b1;
      check("abort_no_frame", 32'(frame_ready), 32'd0);
      sent.delete(); expErr = '0;
      sendChar(9'h07E, 1'b0);
      endFrame(); verifyFrame("abort");

      // Silence with nothing collected must not produce a frame
      rx_silence = 1'b1; @(negedge clk); rx_silence = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_silence", 32'(frame_ready), 32'd0);

      for (int f = 0; f < 16; f++) begin
         n = $urandom_range(1, 7);
         for (int i = 0; i < n; i++) begin
            d  = 9'($urandom_range(0, 511));
            pe = ($urandom_range(0, 7) == 0);
            sendChar(d, pe);
            if ($urandom_range(0, 5) == 0) begin pulseOverflow(); expErr[1] = 1'b1; end
            if ($urandom_range(0, 5) == 0) begin pulseBreak();    expErr[2] = 1'b1; end
         end
         endFrame(); verifyFrame("random");
      end

      // Reset while a frame is held after a read
      sendChar(9'h0C3, 1'b1);
      endFrame();
      rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
      check("pre_rst_rd", 32'(rd_data), 32'h0C3);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      checkAllZero("rst_done");
      sent.delete(); expErr = '0;

      // Reset mid-collection; following frame starts clean
      sendChar(9'h05A, 1'b1); sendChar(9'h05B, 1'b0);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      checkAllZero("rst_recv");
      sent.delete(); expErr = '0;
      @(negedge clk);
      sendChar(9'h123, 1'b0);
      endFrame(); verifyFrame("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
